// File: rtl/bitstream_fetcher.sv
// bitstream_fetcher: fetches WORD_W-bit source words into an MSB-aligned bit FIFO and serves 1..9 bit reads; FETCH_STATS_EN enables the words_fetched counter
module bitstream_fetcher #(
    parameter int WORD_W   = 9,
    parameter int BUF_W    = 32,
    parameter int RESP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              request,
    input  logic [WORD_W-1:0] data,
    input  logic              data_ready,
    input  logic              rd_en,
    input  logic [3:0]        rd_len,
    output logic [8:0]        rd_bits,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [5:0]        bits_avail,
    output logic              eos,
    output logic [15:0]       words_fetched
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, DONE} state_t;
    state_t            state;
    logic [BUF_W-1:0]  buffer;
    logic [2:0]        cnt;
    logic              rd_ok;
    logic              append;
    logic [5:0]        take;
    logic [5:0]        avail_left;
    logic [BUF_W-1:0]  shifted;
    logic [BUF_W-1:0]  placed;
    logic [8:0]        top_bits;

    assign rd_ok      = rd_en && rd_len != 4'd0 && rd_len <= 4'd9 && {2'b00, rd_len} <= bits_avail;
    assign take       = rd_ok ? {2'b00, rd_len} : 6'd0;
    assign avail_left = bits_avail - take;
    assign append     = state == CAPT && data_ready;
    assign shifted    = buffer << take;
    assign placed     = {data, {(BUF_W-WORD_W){1'b0}}} >> avail_left;
    assign top_bits   = buffer[BUF_W-1 -: 9] >> (4'd9 - rd_len);

    // Bit FIFO: a read consumes from the pre-append buffer; a captured word lands just below what remains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer     <= '0;
            bits_avail <= '0;
            rd_bits    <= '0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            rd_valid   <= rd_ok;
            rd_err     <= rd_en && !rd_ok;
            if (rd_ok) rd_bits <= top_bits;
            buffer     <= append ? (shifted | placed) : shifted;
            bits_avail <= append ? avail_left + 6'(WORD_W) : avail_left;
        end
    end

    // Fetch sequencer: one request pulse per word, then wait out the source latency and capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            request <= 1'b0;
            cnt     <= '0;
            eos     <= 1'b0;
        end else begin
            request <= 1'b0;
            case (state)
                IDLE: if (!eos && avail_left <= 6'(BUF_W-WORD_W)) begin
                    state   <= REQ;
                    request <= 1'b1;
                end
                REQ: begin
                    cnt   <= 3'(RESP_LAT-1);
                    state <= (RESP_LAT == 1) ? CAPT : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= CAPT;
                end
                CAPT: if (data_ready) state <= IDLE;
                else begin
                    eos   <= 1'b1;
                    state <= DONE;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating count of words appended to the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) words_fetched <= '0;
        else if (append && words_fetched != 16'hFFFF) words_fetched <= words_fetched + 16'd1;
    end
`else
    assign words_fetched = '0;
`endif
endmodule

// File: tb/tb_bitstream_fetcher.sv
// tb_bitstream_fetcher: scoreboard bench for bitstream_fetcher with a modelled word source
module tb_bitstream_fetcher;
    localparam int LAT = 3;
`ifdef FETCH_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        logic       err;
        logic [8:0] bits;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request;
    logic [8:0]  data;
    logic        data_ready;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_len = 4'd0;
    logic [8:0]  rd_bits;
    logic        rd_valid;
    logic        rd_err;
    logic [5:0]  bits_avail;
    logic        eos;
    logic [15:0] words_fetched;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic [8:0]  src [8];
    int          nsrc = 0;
    int          fcnt = 0;
    bit          bq[$];
    exp_t        sb[$];
    logic [8:0]  last_bits = 9'h0;

    bitstream_fetcher #(.WORD_W(9), .BUF_W(32), .RESP_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .request(request), .data(data), .data_ready(data_ready),
        .rd_en(rd_en), .rd_len(rd_len), .rd_bits(rd_bits), .rd_valid(rd_valid),
        .rd_err(rd_err), .bits_avail(bits_avail), .eos(eos), .words_fetched(words_fetched)
    );

    always #5 clk = ~clk;

    // Word source: each request advances to the next word; past the list it reports no more data
    always @(negedge clk) begin
        if (rst) fcnt = 0;
        else if (request) fcnt++;
    end

    always_comb begin
        data_ready = fcnt >= 1 && fcnt <= nsrc;
        data = data_ready ? src[fcnt-1] : 9'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: request spacing, output exclusivity and scoreboard pops
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rst) prev_req = 1'b0;
        else begin
            if (request) begin
                chk("req_gap", 32'(prev_req), 0);
                req_cnt++;
            end
            prev_req = request;
            if (rd_valid || rd_err) chk("valid_err_excl", 32'(rd_valid & rd_err), 0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rd_valid", 32'(rd_valid), 32'(!e.err));
                chk("rd_err", 32'(rd_err), 32'(e.err));
                chk("rd_bits", 32'(rd_bits), 32'(e.bits));
            end else if (rd_valid || rd_err) chk("spurious_rd", 32'({rd_valid, rd_err}), 0);
        end
    end

    task automatic load(input int n);
        nsrc = n;
        for (int i = 0; i < n; i++)
            for (int b = 8; b >= 0; b--) bq.push_back(src[i][b]);
    endtask

    task automatic rd(input int len);
        exp_t e;
        logic [8:0] v;
        @(negedge clk);
        rd_en = 1'b1;
        rd_len = 4'(len);
        e.due = cyc + 1;
        if (len >= 1 && len <= 9 && len <= bq.size()) begin
            v = 9'h0;
            for (int i = 0; i < len; i++) v = {v[7:0], bq.pop_front()};
            last_bits = v;
            e.err = 1'b0;
        end else e.err = 1'b1;
        e.bits = last_bits;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        bq.delete();
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_request", 32'(request), 0);
        chk("rst_rd_bits", 32'(rd_bits), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_err", 32'(rd_err), 0);
        chk("rst_bits_avail", 32'(bits_avail), 0);
        chk("rst_eos", 32'(eos), 0);
        chk("rst_words", 32'(words_fetched), 0);

        src[0] = 9'h1A5;
        src[1] = 9'h0F3;
        load(2);
        base = req_cnt;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("p1_req_count", 32'(req_cnt - base), 3);
        chk("p1_avail", 32'(bits_avail), 18);
        chk("p1_eos", 32'(eos), 1);
        chk("p1_words", 32'(words_fetched), STATS ? 2 : 0);
        rd(0); rd(10); idle();
        chk("p1_avail_illegal", 32'(bits_avail), 18);
        rd(4); rd(5); rd(9); rd(1); idle();
        chk("p1_drained", 32'(bits_avail), 0);
        base = req_cnt;
        repeat (20) @(negedge clk);
        chk("p1_no_req_after_eos", 32'(req_cnt - base), 0);

        do_reset();
        for (int i = 0; i < 8; i++) src[i] = 9'($urandom);
        load(8);
        base = req_cnt;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("p2_settle_avail", 32'(bits_avail), 27);
        chk("p2_settle_req", 32'(req_cnt - base), 3);
        rd(9); rd(4); idle();
        @(negedge clk);
        chk("p2_pre_capt", 32'(bits_avail), 14);
        rd(9); idle();
        chk("p2_simul_capt", 32'(bits_avail), 14);
        repeat (30) @(negedge clk);
        chk("p2_full", 32'(bits_avail), 32);
        chk("p2_eos_low", 32'(eos), 0);
        rd(9); rd(9); rd(9); idle();
        repeat (60) @(negedge clk);
        chk("p2_eos", 32'(eos), 1);
        chk("p2_tail", 32'(bits_avail), 23);
        rd(9); rd(9); rd(2); rd(5); idle();
        chk("p2_avail3", 32'(bits_avail), 3);
        rd(3); rd(1); idle();
        chk("p2_empty", 32'(bits_avail), 0);

        do_reset();
        for (int i = 0; i < 4; i++) src[i] = 9'($urandom);
        nsrc = 4;
        base = req_cnt;
        rst = 1'b0;
        for (int i = 0; i < 100 && req_cnt - base < 3; i++) @(negedge clk);
        chk("p3_third_req", 32'(req_cnt - base), 3);
        chk("p3_pre_avail", 32'(bits_avail), 18);
        chk("p3_pre_words", 32'(words_fetched), STATS ? 2 : 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("p3_rst_request", 32'(request), 0);
        chk("p3_rst_avail", 32'(bits_avail), 0);
        chk("p3_rst_eos", 32'(eos), 0);
        chk("p3_rst_words", 32'(words_fetched), 0);
        bq.delete();
        src[0] = 9'h13C;
        src[1] = 9'h0AA;
        load(2);
        repeat (2) @(negedge clk);
        base = req_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("p3_first_req", 32'(request), 1);
        repeat (40) @(negedge clk);
        chk("p3_avail", 32'(bits_avail), 18);
        chk("p3_words", 32'(words_fetched), STATS ? 2 : 0);
        chk("p3_req_count", 32'(req_cnt - base), 3);
        chk("p3_eos", 32'(eos), 1);
        rd(9); rd(9); rd(1); idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
